// File: rtl/fir_dvs_pkg.sv
// fir_dvs_pkg: shared types and constants for the DVS FIR filter.
// Holds the default half-band coefficient set, the performance-level type
// and the one-hot voltage-select encoder.
package fir_dvs_pkg;

  localparam int MAX_TAPS  = 32;
  localparam int DEF_COEF_W = 16;

  typedef logic signed [DEF_COEF_W-1:0] def_coef_t;

  // 15-tap half-band (Q1.15), symmetric, zero-padded up to MAX_TAPS
  localparam def_coef_t DEF_COEF [MAX_TAPS] = '{
    -16'sd868, 16'sd0, 16'sd1445, 16'sd0, -16'sd3060, 16'sd0, 16'sd10285, 16'sd16384,
    16'sd10285, 16'sd0, -16'sd3060, 16'sd0, 16'sd1445, 16'sd0, -16'sd868, 16'sd0,
    16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
    16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0
  };

  typedef enum logic [1:0] {
    LVL_LOW  = 2'd0,
    LVL_MED  = 2'd1,
    LVL_HIGH = 2'd2,
    LVL_MAX  = 2'd3
  } level_t;

  // One-hot voltage select for a performance level
  function automatic logic [3:0] level_onehot(input level_t lvl);
    logic [3:0] oh;
    case (lvl)
      LVL_LOW:  oh = 4'b0001;
      LVL_MED:  oh = 4'b0010;
      LVL_HIGH: oh = 4'b0100;
      LVL_MAX:  oh = 4'b1000;
      default:  oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/fir_dvs_axis_monitor.sv
// fir_dvs_monitor: windowed load monitor and hysteretic level FSM.
// Counts accepted beats per WIN-cycle window and steps the performance
// level up/down (saturating) at each window end.
module fir_dvs_monitor
  import fir_dvs_pkg::*;
#(
  parameter int WIN   = 64,
  parameter int UP_TH = 48,
  parameter int DN_TH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  output logic [1:0] level,
  output logic       level_chg,
  output logic [3:0] voltage_sel
);

  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int BCW = $clog2(WIN + 1);

  logic [WCW-1:0] win_cnt_r;
  logic [BCW-1:0] beat_cnt_r;
  logic [BCW-1:0] beat_tot_s;
  logic           win_end_s;
  level_t         level_r;
  level_t         level_nxt_s;

  assign win_end_s  = (win_cnt_r == WCW'(WIN - 1));
  // the fire of the closing cycle is part of the window being judged
  assign beat_tot_s = beat_cnt_r + BCW'(fire);

  // Window and beat counters, restarting together at each window end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_r  <= '0;
      beat_cnt_r <= '0;
    end else if (win_end_s) begin
      win_cnt_r  <= '0;
      beat_cnt_r <= '0;
    end else begin
      win_cnt_r  <= win_cnt_r + WCW'(1);
      beat_cnt_r <= beat_tot_s;
    end
  end

  // Level state register plus registered change pulse and voltage select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r     <= LVL_LOW;
      level_chg   <= 1'b0;
      voltage_sel <= 4'b0001;
    end else begin
      level_r     <= level_nxt_s;
      level_chg   <= (level_nxt_s != level_r);
      voltage_sel <= level_onehot(level_nxt_s);
    end
  end

  // Next level: step up on heavy load, down on light load, saturate at ends
  always_comb begin
    level_nxt_s = level_r;
    if (win_end_s) begin
      if ((beat_tot_s >= BCW'(UP_TH)) && (level_r != LVL_MAX)) begin
        level_nxt_s = level_t'(level_r + 2'd1);
      end else if ((beat_tot_s <= BCW'(DN_TH)) && (level_r != LVL_LOW)) begin
        level_nxt_s = level_t'(level_r - 2'd1);
      end else begin
        level_nxt_s = level_r;
      end
    end else begin
      level_nxt_s = level_r;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/fir_dvs_axis.sv
// fir_dvs_axis: AXI-Stream FIR with programmable coefficients and a
// load-driven DVS level controller.
// Pipeline: S0 delay line -> S1 products -> S2 sum -> S3 output register.
// Optional macro FIR_ROUND_EN: rescale the sum by COEF_W-1 with round-half-up
// and saturate to signed OUT_W; otherwise the full sum is sign-extended or
// truncated to OUT_W.
module fir_dvs_axis
  import fir_dvs_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 15,
  parameter int OUT_W  = 32,
  parameter int KEEP_W = 4,
  parameter int WIN    = 64,
  parameter int UP_TH  = 48,
  parameter int DN_TH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [OUT_W-1:0]  m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic              coef_we,
  input  logic [4:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic [1:0]        perf_level,
  output logic [3:0]        voltage_sel,
  output logic              level_chg
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int GROW_W = $clog2(NTAPS);
  localparam int SUM_W  = PROD_W + GROW_W;

  logic signed [COEF_W-1:0] coef_r [NTAPS];
  logic signed [DATA_W-1:0] x_r    [NTAPS];
  logic signed [PROD_W-1:0] prod_r [NTAPS];
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [SUM_W-1:0]  sum_r;
  logic [OUT_W-1:0]         out_s;

  logic              v0_r, v1_r, v2_r;
  logic              last0_r, last1_r, last2_r;
  logic [KEEP_W-1:0] keep0_r, keep1_r, keep2_r;

  logic adv_s;
  logic s_fire_s;

  // whole pipeline advances whenever the output slot is free or draining
  assign adv_s    = ~m_tvalid | m_tready;
  assign s_tready = adv_s & ~reset;
  assign s_fire_s = s_tvalid & s_tready;

  // Coefficient bank: defaults on reset, single-entry writes, out-of-range ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef_r[k] <= COEF_W'(DEF_COEF[k]);
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (coef_we && (coef_addr == 5'(k))) begin
          coef_r[k] <= coef_wdata;
        end
      end
    end
  end

  // S0: delay line shifts only on an accepted beat; kept across packets
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_r[k] <= '0;
      end
    end else if (s_fire_s) begin
      x_r[0] <= s_tdata;
      for (int k = 1; k < NTAPS; k++) begin
        x_r[k] <= x_r[k-1];
      end
    end
  end

  // Sideband tags travel with their sample through S0..S2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_r    <= 1'b0;
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      last0_r <= 1'b0;
      last1_r <= 1'b0;
      last2_r <= 1'b0;
      keep0_r <= '0;
      keep1_r <= '0;
      keep2_r <= '0;
    end else if (adv_s) begin
      v0_r    <= s_fire_s;
      last0_r <= s_fire_s & s_tlast;
      keep0_r <= s_fire_s ? s_tkeep : '0;
      v1_r    <= v0_r;
      last1_r <= last0_r;
      keep1_r <= keep0_r;
      v2_r    <= v1_r;
      last2_r <= last1_r;
      keep2_r <= keep1_r;
    end
  end

  // S1: one registered product per tap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod_r[k] <= '0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod_r[k] <= PROD_W'(coef_r[k]) * PROD_W'(x_r[k]);
      end
    end
  end

  // Adder tree at full width with log2(NTAPS) guard bits
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum_s = sum_s + SUM_W'(prod_r[k]);
    end
  end

  // S2: registered sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r <= '0;
    end else if (adv_s) begin
      sum_r <= sum_s;
    end
  end

`ifdef FIR_ROUND_EN
  localparam int RND_W = (SUM_W + 1 > OUT_W) ? SUM_W + 1 : OUT_W + 1;
  localparam logic signed [RND_W-1:0] RND_HALF =
    {{(RND_W-1){1'b0}}, 1'b1} << (COEF_W - 2);
  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [RND_W-1:0] rnd_s;

  // Rescale Q.(COEF_W-1) sum with round-half-up, then clamp to signed OUT_W
  always_comb begin
    rnd_s = (RND_W'(sum_r) + RND_HALF) >>> (COEF_W - 1);
    if (rnd_s > SAT_MAX) begin
      out_s = SAT_MAX[OUT_W-1:0];
    end else if (rnd_s < SAT_MIN) begin
      out_s = SAT_MIN[OUT_W-1:0];
    end else begin
      out_s = rnd_s[OUT_W-1:0];
    end
  end
`else
  // Full-precision sum, sign-extended or truncated to the output width
  always_comb begin
    out_s = OUT_W'(sum_r);
  end
`endif

  // S3: output register, frozen while the sink stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tkeep  <= '0;
    end else if (adv_s) begin
      m_tvalid <= v2_r;
      m_tdata  <= out_s;
      m_tlast  <= last2_r;
      m_tkeep  <= keep2_r;
    end
  end

  fir_dvs_monitor #(
    .WIN   (WIN),
    .UP_TH (UP_TH),
    .DN_TH (DN_TH)
  ) u_monitor (
    .clk         (clk),
    .reset       (reset),
    .fire        (s_fire_s),
    .level       (perf_level),
    .level_chg   (level_chg),
    .voltage_sel (voltage_sel)
  );

endmodule
